// File: rtl/dff_arb_pkg.sv
// rtl/dff_arb_pkg.sv - shared types, defaults and one-hot helper for the DFF write arbiter
package dff_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_t;

    localparam int DEF_NREQ        = 4;
    localparam int DEF_WIDTH       = 8;
    localparam int DEF_HOLD_CYCLES = 2;

    // Widest grant vector the helper can build; callers size-cast down to NREQ.
    localparam int MAX_NREQ = 32;

    function automatic logic [MAX_NREQ-1:0] onehot(input int unsigned idx);
        logic [MAX_NREQ-1:0] v;
        v = '0;
        v[idx[4:0]] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker: first asserted req at or after ptr
module rr_pick
    import dff_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] win,
    output logic            valid
);

    int idx;

    always_comb begin
        win   = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!valid && req[idx]) begin
                valid = 1'b1;
                win   = IDXW'(idx);
            end
        end
    end

endmodule

// File: rtl/dff_write_arbiter.sv
// rtl/dff_write_arbiter.sv - one-at-a-time writer for a shared register with post-write hold
// Define DFF_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module dff_write_arbiter
    import dff_arb_pkg::*;
#(
    parameter int NREQ        = DEF_NREQ,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     data,
    output logic [NREQ-1:0]           gnt,
    output logic [WIDTH-1:0]          q,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy
);

    localparam int IDXW = $clog2(NREQ);
    localparam int CNTW = $clog2(HOLD_CYCLES + 1);

    if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
        $error("dff_write_arbiter: NREQ out of range");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("dff_write_arbiter: HOLD_CYCLES must be at least 1");
    end

    arb_state_t      state;
    logic [CNTW-1:0] cnt;
    logic [IDXW-1:0] win;
    logic            win_valid;
    logic [WIDTH-1:0] win_data;

`ifdef DFF_ARB_FIXED_PRIO_EN
    // Rotation anchored at 0 makes the picker a plain lowest-index priority encoder.
    rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
        .req   (req),
        .ptr   ('0),
        .win   (win),
        .valid (win_valid)
    );
`else
    logic [IDXW-1:0] ptr;

    rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .win   (win),
        .valid (win_valid)
    );
`endif

    assign win_data = data[win*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            q     <= '0;
            gnt   <= '0;
            owner <= '0;
            busy  <= 1'b0;
`ifndef DFF_ARB_FIXED_PRIO_EN
            ptr   <= '0;
`endif
        end else begin
            gnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        q     <= win_data;
                        gnt   <= NREQ'(onehot(32'(win)));
                        owner <= win;
                        cnt   <= CNTW'(HOLD_CYCLES - 1);
                        busy  <= 1'b1;
                        state <= ST_HOLD;
`ifndef DFF_ARB_FIXED_PRIO_EN
                        if (win == IDXW'(NREQ - 1)) begin
                            ptr <= '0;
                        end else begin
                            ptr <= win + 1'b1;
                        end
`endif
                    end
                end
                ST_HOLD: begin
                    // Requests are not looked at here; the register stays frozen.
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff_write_arbiter.sv
// tb/tb_dff_write_arbiter.sv - scoreboard bench for dff_write_arbiter at default parameters
module tb_dff_write_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic [1:0]            owner;
    logic                  busy;

    typedef struct {
        logic [NREQ-1:0]  g;
        logic [WIDTH-1:0] d;
        logic [1:0]       o;
    } exp_t;

    exp_t exp_q[$];
    int   compared;
    int   mismatched;
    int   cyc;
    bit   seen_g1;

    dff_write_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_CYCLES(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .data  (data),
        .gnt   (gnt),
        .q     (q),
        .owner (owner),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && gnt !== '0) begin
            if (gnt[1]) seen_g1 = 1'b1;
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_gnt: gnt=%b q=%h owner=%0d", gnt, q, owner);
            end else begin
                e = exp_q.pop_front();
                if (gnt !== e.g || q !== e.d || owner !== e.o || busy !== 1'b1) begin
                    mismatched++;
                    $display("FAIL grant: got gnt=%b q=%h owner=%0d busy=%b, want gnt=%b q=%h owner=%0d busy=1",
                             gnt, q, owner, busy, e.g, e.d, e.o);
                end
            end
        end
    end

    function automatic exp_t mk(input int idx, input logic [WIDTH-1:0] d);
        exp_t e;
        e.g = '0;
        e.g[idx] = 1'b1;
        e.d = d;
        e.o = 2'(idx);
        return e;
    endfunction

    task automatic do_reset();
        req = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_gnt(output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt !== '0) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL gnt_timeout: no grant within 20 cycles, want one");
        end
    endtask

    task automatic check_drained(input string name);
        repeat (6) @(negedge clk);
        compared++;
        if (exp_q.size() !== 0) begin
            mismatched++;
            $display("FAIL %s_drain: %0d grants outstanding, want 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req  = 4'($urandom);
            data = 32'($urandom);
            @(negedge clk);
            compared++;
            if (q !== 8'h00 || gnt !== 4'b0000 || owner !== 2'd0 || busy !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_hold: q=%h gnt=%b owner=%0d busy=%b, want 00/0000/0/0", q, gnt, owner, busy);
            end
        end
        do_reset();
    endtask

    task automatic test_single_write();
        bit ok;
        int at;
        do_reset();
        data = '0;
        data[2*WIDTH +: WIDTH] = 8'hA5;
        req = 4'b0100;
        exp_q.push_back(mk(2, 8'hA5));
        wait_gnt(ok, at);
        req = '0;
        @(negedge clk);
        compared++;
        if (busy !== 1'b1 || gnt !== 4'b0000 || q !== 8'hA5) begin
            mismatched++;
            $display("FAIL single_hold2: busy=%b gnt=%b q=%h, want 1/0000/a5", busy, gnt, q);
        end
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || q !== 8'hA5 || owner !== 2'd2) begin
            mismatched++;
            $display("FAIL single_idle: busy=%b q=%h owner=%0d, want 0/a5/2", busy, q, owner);
        end
        check_drained("single");
    endtask

    task automatic test_round_robin();
        bit ok;
        int at;
        int prev;
        int idx;
        do_reset();
        for (int i = 0; i < NREQ; i++) data[i*WIDTH +: WIDTH] = 8'(8'h10 + i);
        for (int i = 0; i < 5; i++) begin
`ifdef DFF_ARB_FIXED_PRIO_EN
            idx = 0;
`else
            idx = i % NREQ;
`endif
            exp_q.push_back(mk(idx, 8'(8'h10 + idx)));
        end
        req = 4'b1111;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(ok, at);
            if (i == 4) req = '0;
            if (ok && i > 0) begin
                compared++;
                if (at - prev !== 3) begin
                    mismatched++;
                    $display("FAIL rr_spacing: grant %0d spacing=%0d, want 3", i, at - prev);
                end
            end
            prev = at;
        end
        check_drained("rr");
    endtask

    task automatic test_withdraw();
        bit ok;
        int at;
        do_reset();
        seen_g1 = 1'b0;
        data = '0;
        data[0 +: WIDTH]     = 8'h20;
        data[WIDTH +: WIDTH] = 8'h21;
        exp_q.push_back(mk(0, 8'h20));
        exp_q.push_back(mk(0, 8'h20));
        req = 4'b0011;
        wait_gnt(ok, at);
        req = 4'b0001;
        wait_gnt(ok, at);
        req = '0;
        check_drained("withdraw");
        compared++;
        if (seen_g1 !== 1'b0) begin
            mismatched++;
            $display("FAIL withdraw_no_gnt1: gnt[1] seen=%b, want 0", seen_g1);
        end
    endtask

    task automatic test_reset_mid_hold();
        bit ok;
        int at;
        do_reset();
        data = '0;
        data[2*WIDTH +: WIDTH] = 8'h5C;
        data[3*WIDTH +: WIDTH] = 8'h33;
        exp_q.push_back(mk(2, 8'h5C));
        req = 4'b0100;
        wait_gnt(ok, at);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        compared++;
        if (q !== 8'h00 || gnt !== 4'b0000 || owner !== 2'd0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset: q=%h gnt=%b owner=%0d busy=%b, want 00/0000/0/0", q, gnt, owner, busy);
        end
        exp_q.delete();
        exp_q.push_back(mk(2, 8'h5C));
        req = 4'b1100;
        @(negedge clk);
        rst = 1'b0;
        wait_gnt(ok, at);
        req = '0;
        check_drained("mid_reset");
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        seen_g1    = 1'b0;
        rst        = 1'b1;
        req        = '0;
        data       = '0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_withdraw();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
